ps2_key_fifo: RTL
=================

PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: number of key-event entries; SHALL be a power of two, 2..64.
REQ-002 Parameter FILTER_LEN, default 8: consecutive equal ps2c samples required to change the filtered clock level.
REQ-003 Parameter TIMEOUT_CYC, default 3000: count of filtered-clock-high cycles after which a partial frame SHALL be abandoned.
REQ-004 clk_50mhz  in  1  single system clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 ps2c  in  1  PS/2 clock, asynchronous.
REQ-007 ps2d  in  1  PS/2 data, asynchronous.
REQ-008 rd_en  in  1  pop the head entry when key_valid is high.
REQ-009 key_code  out  8  scan code of the head entry (first-word fall-through).
REQ-010 key_ext  out  1  head entry was preceded by E0.
REQ-011 key_brk  out  1  head entry was preceded by F0 (key release).
REQ-012 key_valid  out  1  FIFO not empty.
REQ-013 fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-014 count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-015 overflow  out  1  sticky: an event was dropped because the FIFO was full.
REQ-016 frame_err  out  1  one-cycle pulse: frame discarded (parity or stop error).

Function
REQ-017 ps2c and ps2d SHALL each pass through a two-flop synchroniser before use.
REQ-018 The filtered clock SHALL change level only after FILTER_LEN consecutive synchronised samples at the new level; a falling edge of the filtered clock SHALL produce a one-cycle sample strobe.
REQ-019 The receiver FSM SHALL have the states IDLE, DATA, PARITY and STOP, and SHALL advance only on a sample strobe.
REQ-020 IDLE: data 0 on strobe -> DATA with bit counter 0; data 1 -> remain in IDLE with no error.
REQ-021 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-022 PARITY: capture the bit -> STOP.
REQ-023 STOP: byte is accepted if the stop bit is 1 and data plus parity have odd parity; otherwise discard, pulse frame_err in the following cycle, and go to IDLE.
REQ-024 In any state other than IDLE, TIMEOUT_CYC consecutive cycles of filtered clock high SHALL return the FSM to IDLE, discard the partial byte, and not pulse frame_err.
REQ-025 An accepted byte E0 SHALL set the pending ext flag and write nothing.
REQ-026 An accepted byte F0 SHALL set the pending brk flag and write nothing.
REQ-027 Any other accepted byte SHALL write {ext, brk, byte} to the FIFO and clear both pending flags.
REQ-028 Latency: key_valid SHALL rise exactly 2 cycles after the stop-bit strobe cycle when the FIFO was empty.
REQ-029 The FIFO is first-word fall-through: key_code, key_ext and key_brk are valid whenever key_valid is high, and the next entry appears in the cycle after a pop.
REQ-030 rd_en while empty SHALL be ignored; pointers and count SHALL be unchanged.
REQ-031 A write when full with no pop in the same cycle SHALL drop the event, set overflow, and leave the FIFO unchanged.
REQ-032 A write and a pop in the same cycle, including when full, SHALL both take effect; count is unchanged and overflow is not set.
REQ-033 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL distinguish empty (0) from full (FIFO_DEPTH).
REQ-034 overflow SHALL clear only on reset.

Reset
REQ-035 reset low SHALL immediately force: FSM IDLE, bit counter 0, filter and synchronisers to logic 1, timeout counter 0, pending flags 0, FIFO empty, key_valid 0, fifo_full 0, count 0, overflow 0, frame_err 0, key_code 8'h00, key_ext 0, key_brk 0.
REQ-036 reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL resume at the next start bit.

Verification
REQ-037 Frame 0x1C with correct parity, FIFO empty -> key_valid rises 2 cycles after the stop strobe; key_code 1C, ext 0, brk 0, count 1.
REQ-038 Sequence E0, F0, 0x75 -> exactly one entry: key_code 75, ext 1, brk 1; a following 0x1C -> entry 1C, ext 0, brk 0.
REQ-039 Frame 0x1C with the parity bit inverted -> one frame_err pulse, no FIFO write; same result for stop bit 0.
REQ-040 FIFO_DEPTH+1 codes written with no reads -> fifo_full 1, count FIFO_DEPTH, overflow 1, and the first FIFO_DEPTH codes are read back in order.
REQ-041 ps2c held high for TIMEOUT_CYC cycles after 4 data bits, then a full 0x29 frame -> only 29 is written; frame_err never pulses.
REQ-042 Glitch of FILTER_LEN-1 cycles low on ps2c while idle -> no strobe and no state change; full FIFO plus simultaneous pop and write -> count unchanged, overflow stays 0.

Source files
------------

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: synchronised, glitch-filtered clock; 11-bit frame decoder;
// E0/F0 prefix folding; first-word fall-through key-event FIFO.
module ps2_key_fifo #(
   parameter int FIFO_DEPTH  = 8,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 3000
) (
   input  logic                          clk_50mhz,
   input  logic                          reset,
   input  logic                          ps2c,
   input  logic                          ps2d,
   input  logic                          rd_en,
   output logic [7:0]                    key_code,
   output logic                          key_ext,
   output logic                          key_brk,
   output logic                          key_valid,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic                          frame_err,
   output logic [1:0]                    o_dbg_state
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0]    r_c_sync, r_d_sync;
   logic          r_filt, r_strobe, r_bit;
   logic [FW-1:0] r_filt_cnt;
   logic [TW-1:0] r_to_cnt;
   state_t        r_state, w_state_n;
   logic [2:0]    r_bit_cnt, w_bit_cnt_n;
   logic [7:0]    r_shift, w_shift_n, r_byte;
   logic          r_par, w_par_n, w_accept, w_err, w_timeout;
   logic          r_byte_vld, r_frame_err, r_ext, r_brk, r_overflow;
   logic [9:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_empty, w_full, w_wr, w_pop, w_push;
   logic [9:0]    w_head;

   always_ff @(posedge clk_50mhz or negedge reset) begin
      if (!reset) begin
         r_c_sync <= '1;
         r_d_sync <= '1;
      end else begin
         r_c_sync <= {r_c_sync[0], ps2c};
         r_d_sync <= {r_d_sync[0], ps2d};
      end
   end

   // Data is captured on the same cycle the filtered clock falls, so it lines up with the strobe.
   always_ff @(posedge clk_50mhz or negedge reset) begin
      if (!reset) begin
         r_filt     <= 1'b1;
         r_filt_cnt <= '0;
         r_strobe   <= 1'b0;
         r_bit      <= 1'b1;
      end else begin
         r_strobe <= 1'b0;
         if (r_c_sync[1] == r_filt) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
            r_filt     <= r_c_sync[1];
            r_filt_cnt <= '0;
            r_strobe   <= ~r_c_sync[1];
            r_bit      <= r_d_sync[1];
         end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
         end
      end
   end

   assign w_timeout = (r_state != S_IDLE) && r_filt && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_50mhz or negedge reset) begin
      if (!reset)                            r_to_cnt <= '0;
      else if (r_state == S_IDLE || !r_filt) r_to_cnt <= '0;
      else if (!w_timeout)                   r_to_cnt <= r_to_cnt + TW'(1);
   end

   always_ff @(posedge clk_50mhz or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par     <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_bit_cnt <= w_bit_cnt_n;
         r_shift   <= w_shift_n;
         r_par     <= w_par_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_bit_cnt_n = r_bit_cnt;
      w_shift_n   = r_shift;
      w_par_n     = r_par;
      w_accept    = 1'b0;
      w_err       = 1'b0;
      if (w_timeout) begin
         w_state_n   = S_IDLE;
         w_bit_cnt_n = '0;
      end else if (r_strobe) begin
         case (r_state)
            S_IDLE: if (!r_bit) begin
               w_state_n   = S_DATA;
               w_bit_cnt_n = '0;
            end
            S_DATA: begin
               w_shift_n   = {r_bit, r_shift[7:1]};
               w_bit_cnt_n = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) w_state_n = S_PARITY;
            end
            S_PARITY: begin
               w_par_n   = r_bit;
               w_state_n = S_STOP;
            end
            default: begin
               w_state_n = S_IDLE;
               if (r_bit && (^{r_shift, r_par})) w_accept = 1'b1;
               else                              w_err    = 1'b1;
            end
         endcase
      end
   end

   assign o_dbg_state = r_state;

   always_ff @(posedge clk_50mhz or negedge reset) begin
      if (!reset) begin
         r_byte_vld  <= 1'b0;
         r_byte      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_byte_vld  <= w_accept;
         r_frame_err <= w_err;
         if (w_accept) r_byte <= r_shift;
      end
   end

   // Prefix bytes only arm flags; any other byte consumes them even if the FIFO drops it.
   assign w_wr = r_byte_vld && (r_byte != 8'hE0) && (r_byte != 8'hF0);

   always_ff @(posedge clk_50mhz or negedge reset) begin
      if (!reset) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (r_byte_vld) begin
         if (r_byte == 8'hE0)      r_ext <= 1'b1;
         else if (r_byte == 8'hF0) r_brk <= 1'b1;
         else begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
         end
      end
   end

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == (AW + 1)'(FIFO_DEPTH));
   assign w_pop   = rd_en && !w_empty;
   assign w_push  = w_wr && (!w_full || w_pop);

   always_ff @(posedge clk_50mhz) begin
      if (w_push) r_mem[r_wr_ptr] <= {r_ext, r_brk, r_byte};
   end

   always_ff @(posedge clk_50mhz or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW + 1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (AW + 1)'(1);
         if (w_wr && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign w_head    = r_mem[r_rd_ptr];
   assign key_code  = w_empty ? 8'h00 : w_head[7:0];
   assign key_brk   = w_empty ? 1'b0  : w_head[8];
   assign key_ext   = w_empty ? 1'b0  : w_head[9];
   assign key_valid = !w_empty;
   assign fifo_full = w_full;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign frame_err = r_frame_err;
endmodule
